// File: rtl/video_stream_unpacker.sv
// AXI4-Stream video sink: unpacks 3 x 32-bit words into 4 RGB888 pixels,
// tracks x/y from tuser/tlast and flags framing errors.
module video_stream_unpacker #(
  parameter int X_SIZE     = 640,
  parameter int Y_SIZE     = 480,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           in_stream_tdata,
  input  logic [3:0]            in_stream_tkeep,
  input  logic                  in_stream_tlast,
  input  logic                  in_stream_tuser,
  input  logic                  in_stream_tvalid,
  output logic                  in_stream_tready,
  output logic [7:0]            pix_r,
  output logic [7:0]            pix_g,
  output logic [7:0]            pix_b,
  output logic [9:0]            pix_x,
  output logic [8:0]            pix_y,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [FCNT_WIDTH-1:0] frame_count,
  output logic                  err_tlast,
  output logic                  err_sof,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {W0, W1, W2, W2B} state_t;

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [9:0] X_PEN  = 10'(X_SIZE - 2);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  state_t                  r_state;
  logic [23:0]             r_hold;
  logic [9:0]              r_nx;
  logic [8:0]              r_ny;
  logic [23:0]             r_pix;
  logic [9:0]              r_px;
  logic [8:0]              r_py;
  logic                    r_sof;
  logic                    r_eol;
  logic                    r_valid;
  logic [FCNT_WIDTH-1:0]   r_fcnt;
  logic                    r_err_tlast;
  logic                    r_err_sof;

  state_t                  w_state_nxt;
  state_t                  w_st_eff;
  logic                    w_slot_free;
  logic                    w_tready;
  logic                    w_acc;
  logic                    w_sof;
  logic                    w_sof_err;
  logic                    w_last_exp;
  logic                    w_tlast_err;
  logic                    w_early;
  logic [9:0]              w_x_eff;
  logic [8:0]              w_y_eff;
  logic                    w_emit;
  logic [23:0]             w_pix;
  logic [9:0]              w_ex;
  logic [8:0]              w_ey;
  logic [23:0]             w_hold_nxt;
  logic [9:0]              w_nx_nxt;
  logic [8:0]              w_ny_nxt;
  logic                    w_unused;

  assign w_unused    = &{1'b0, in_stream_tkeep};
  assign w_slot_free = !r_valid | pix_ready;
  assign w_tready    = w_slot_free & (r_state != W2B) & aresetn;
  assign w_acc       = in_stream_tvalid & w_tready;
  assign w_sof       = w_acc & in_stream_tuser;

  // A SOF word is processed as w0 of (0,0); the tlast check then runs against that position.
  assign w_st_eff    = w_sof ? W0 : r_state;
  assign w_x_eff     = w_sof ? '0 : r_nx;
  assign w_y_eff     = w_sof ? '0 : r_ny;
  assign w_sof_err   = w_sof & ((r_state != W0) | (r_nx != '0) | (r_ny != '0));
  assign w_last_exp  = (w_st_eff == W2) & (w_x_eff == X_PEN);
  assign w_tlast_err = w_acc & (in_stream_tlast != w_last_exp);
  assign w_early     = w_acc & in_stream_tlast & !w_last_exp;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= W0;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_emit      = 1'b0;
    w_pix       = r_hold;
    w_ex        = r_nx;
    w_ey        = r_ny;
    if (w_acc) begin
      w_emit = 1'b1;
      w_ex   = w_x_eff;
      w_ey   = w_y_eff;
      case (w_st_eff)
        W0: begin
          w_pix       = in_stream_tdata[23:0];
          w_hold_nxt  = {16'h0000, in_stream_tdata[31:24]};
          w_state_nxt = W1;
        end
        W1: begin
          w_pix       = {in_stream_tdata[15:0], r_hold[7:0]};
          w_hold_nxt  = {8'h00, in_stream_tdata[31:16]};
          w_state_nxt = W2;
        end
        W2: begin
          w_pix       = {in_stream_tdata[7:0], r_hold[15:0]};
          w_hold_nxt  = in_stream_tdata[31:8];
          w_state_nxt = W2B;
        end
        default: ;
      endcase
      if (w_early) begin
        w_hold_nxt  = '0;
        w_state_nxt = W0;
      end
    end else if ((r_state == W2B) && w_slot_free) begin
      w_emit      = 1'b1;
      w_pix       = r_hold;
      w_hold_nxt  = '0;
      w_state_nxt = W0;
    end

    w_nx_nxt = r_nx;
    w_ny_nxt = r_ny;
    if (w_emit) begin
      if (w_early || (w_ex == X_LAST)) begin
        w_nx_nxt = '0;
        w_ny_nxt = (w_ey == Y_LAST) ? '0 : w_ey + 9'd1;
      end else begin
        w_nx_nxt = w_ex + 10'd1;
        w_ny_nxt = w_ey;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hold      <= '0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_pix       <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_valid     <= 1'b0;
      r_fcnt      <= '0;
      r_err_tlast <= 1'b0;
      r_err_sof   <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_nx   <= w_nx_nxt;
      r_ny   <= w_ny_nxt;
      if (w_emit) begin
        r_valid <= 1'b1;
        r_pix   <= w_pix;
        r_px    <= w_ex;
        r_py    <= w_ey;
        r_sof   <= (w_ex == '0) && (w_ey == '0);
        r_eol   <= (w_ex == X_LAST);
      end else if (pix_ready) begin
        r_valid <= 1'b0;
      end
      if (w_sof) r_fcnt <= r_fcnt + 1'b1;
      if (w_tlast_err)  r_err_tlast <= 1'b1;
      else if (err_clr) r_err_tlast <= 1'b0;
      if (w_sof_err)    r_err_sof <= 1'b1;
      else if (err_clr) r_err_sof <= 1'b0;
    end
  end

  assign in_stream_tready = w_tready;
  assign pix_r            = r_pix[23:16];
  assign pix_g            = r_pix[15:8];
  assign pix_b            = r_pix[7:0];
  assign pix_x            = r_px;
  assign pix_y            = r_py;
  assign pix_sof          = r_sof;
  assign pix_eol          = r_eol;
  assign pix_valid        = r_valid;
  assign frame_count      = r_fcnt;
  assign err_tlast        = r_err_tlast;
  assign err_sof          = r_err_sof;

endmodule
